// File: rtl/univ_shift_pkg.sv
// Shared encodings for the universal shift register: operation codes, FSM states and the
// burst-eligibility helper.
package univ_shift_pkg;

  localparam logic [2:0] MODE_HOLD = 3'b000;
  localparam logic [2:0] MODE_SHR  = 3'b001;
  localparam logic [2:0] MODE_SHL  = 3'b010;
  localparam logic [2:0] MODE_LOAD = 3'b011;
  localparam logic [2:0] MODE_ROR  = 3'b100;
  localparam logic [2:0] MODE_ROL  = 3'b101;
  localparam logic [2:0] MODE_ASR  = 3'b110;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_e;

  // Only true shift/rotate ops may be repeated in a burst; hold, load and reserved may not.
  function automatic logic is_burst_mode(input logic [2:0] mode);
    return (mode == MODE_SHR) || (mode == MODE_SHL) || (mode == MODE_ROR) ||
           (mode == MODE_ROL) || (mode == MODE_ASR);
  endfunction

endpackage

// File: rtl/shift_op_unit.sv
// Combinational next-value function for one shift-register operation; shared by the
// single-step and burst paths.
module shift_op_unit
  import univ_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  logic [2:0]       op_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic             sdr_i,
  input  logic             sdl_i,
  input  logic [WIDTH-1:0] d_i,
  output logic [WIDTH-1:0] q_nxt_o
);

  always_comb begin
    q_nxt_o = q_i;
    case (op_i)
      MODE_SHR:  q_nxt_o = {sdr_i, q_i[WIDTH-1:1]};
      MODE_SHL:  q_nxt_o = {q_i[WIDTH-2:0], sdl_i};
      MODE_LOAD: q_nxt_o = d_i;
      MODE_ROR:  q_nxt_o = {q_i[0], q_i[WIDTH-1:1]};
      MODE_ROL:  q_nxt_o = {q_i[WIDTH-2:0], q_i[WIDTH-1]};
      MODE_ASR:  q_nxt_o = {q_i[WIDTH-1], q_i[WIDTH-1:1]};
      default:   q_nxt_o = q_i;
    endcase
  end

endmodule

// File: rtl/univ_shift_reg.sv
// Universal shift register with single-step ops and a counted burst engine
// (IDLE -> RUN -> DONE) reporting busy/done.
module univ_shift_reg
  import univ_shift_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNTW  = 4
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic [2:0]       mode_i,
  input  logic             sdr_i,
  input  logic             sdl_i,
  input  logic [WIDTH-1:0] d_i,
  input  logic             start_i,
  input  logic [CNTW-1:0]  count_i,
  output logic [WIDTH-1:0] q_o,
  output logic             so_r_o,
  output logic             so_l_o,
  output logic             busy_o,
  output logic             done_o
);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [CNTW-1:0]  rem_q, rem_d;
  logic [2:0]       op_q, op_d;
  logic [2:0]       op_sel;
  logic [WIDTH-1:0] q_nxt;
  logic             accept;

  // In RUN the latched op drives the datapath so mode_i changes cannot disturb a burst.
  assign op_sel = (state_q == ST_RUN) ? op_q : mode_i;
  assign accept = start_i && (count_i != '0) && is_burst_mode(mode_i);

  shift_op_unit #(
    .WIDTH(WIDTH)
  ) u_shift_op_unit (
    .op_i   (op_sel),
    .q_i    (q_q),
    .sdr_i  (sdr_i),
    .sdl_i  (sdl_i),
    .d_i    (d_i),
    .q_nxt_o(q_nxt)
  );

  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rem_d   = rem_q;
    op_d    = op_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          op_d    = mode_i;
          rem_d   = count_i;
          state_d = ST_RUN;
        end else if (en_i) begin
          q_d = q_nxt;
        end
      end
      ST_RUN: begin
        if (en_i) begin
          q_d   = q_nxt;
          rem_d = rem_q - CNTW'(1);
          if (rem_q == CNTW'(1)) begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      state_q <= ST_IDLE;
      q_q     <= '0;
      rem_q   <= '0;
      op_q    <= MODE_HOLD;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rem_q   <= rem_d;
      op_q    <= op_d;
    end
  end

  assign q_o    = q_q;
  assign so_r_o = q_q[0];
  assign so_l_o = q_q[WIDTH-1];
  assign busy_o = (state_q == ST_RUN);
  assign done_o = (state_q == ST_DONE);

endmodule

// File: tb/tb_univ_shift_reg.sv
// Directed self-checking bench for univ_shift_reg: a 4-bit and an 8-bit instance share the
// control stimulus.
module tb_univ_shift_reg;

  logic       clk = 1'b0;
  logic       clr, en, sdr, sdl, start;
  logic [2:0] mode;
  logic [7:0] d;
  logic [3:0] d4;
  logic [3:0] count;

  logic [7:0] q8;
  logic       so_r8, so_l8, busy8, done8;
  logic [3:0] q4;
  logic       so_r4, so_l4, busy4, done4;

  int n_checks = 0;
  int n_errors = 0;
  int busy_cyc, done_cyc;

  always #5 clk = ~clk;

  univ_shift_reg #(.WIDTH(8), .CNTW(4)) dut8 (
    .clk_i(clk), .clr_i(clr), .en_i(en), .mode_i(mode), .sdr_i(sdr), .sdl_i(sdl),
    .d_i(d), .start_i(start), .count_i(count), .q_o(q8), .so_r_o(so_r8), .so_l_o(so_l8),
    .busy_o(busy8), .done_o(done8)
  );

  univ_shift_reg #(.WIDTH(4), .CNTW(4)) dut4 (
    .clk_i(clk), .clr_i(clr), .en_i(en), .mode_i(mode), .sdr_i(sdr), .sdl_i(sdl),
    .d_i(d4), .start_i(start), .count_i(count), .q_o(q4), .so_r_o(so_r4), .so_l_o(so_l4),
    .busy_o(busy4), .done_o(done4)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issues a burst start, then runs a fixed window of edges counting busy and done cycles.
  task automatic burst(input logic [2:0] op, input logic [3:0] n, output int nb, output int nd);
    nb = 0;
    nd = 0;
    mode  = op;
    count = n;
    start = 1'b1;
    en    = 1'b1;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (i == 0) begin
        start = 1'b0;
        mode  = 3'b000;
      end
      if (busy8) nb++;
      if (done8) nd++;
    end
  endtask

  initial begin
    clr = 1'b1; en = 1'b0; sdr = 1'b0; sdl = 1'b0; start = 1'b0;
    mode = 3'b000; d = 8'h00; d4 = 4'h0; count = 4'd0;

    // Reset and right shift on the 4-bit instance
    tick();
    chk("rst_q4", q4, 4'h0);
    chk("rst_busy4", busy4, 1'b0);
    chk("rst_done4", done4, 1'b0);
    chk("rst_q8", q8, 8'h00);
    chk("rst_so8", {so_l8, so_r8}, 2'b00);
    clr = 1'b0; en = 1'b1; mode = 3'b001; sdr = 1'b1;
    tick(); chk("shr1_q4", q4, 4'b1000);
    tick(); chk("shr2_q4", q4, 4'b1100);
    tick(); chk("shr3_q4", q4, 4'b1110);
    sdr = 1'b0;
    tick(); chk("shr4_q4", q4, 4'b0111);
    chk("shr4_so_r4", so_r4, 1'b1);
    chk("shr4_so_l4", so_l4, 1'b0);
    chk("shr4_busy4", {busy4, done4}, 2'b00);

    // Load and single steps on the 8-bit instance
    mode = 3'b011; d = 8'hA5;
    tick(); chk("load_a5", q8, 8'hA5);
    mode = 3'b100;
    tick(); chk("ror", q8, 8'hD2);
    mode = 3'b101;
    tick(); chk("rol", q8, 8'hA5);
    mode = 3'b010; sdl = 1'b1;
    tick(); chk("shl_sdl1", q8, 8'h4B);
    sdl = 1'b0; mode = 3'b011; d = 8'h90;
    tick(); chk("load_90", q8, 8'h90);
    mode = 3'b110;
    tick(); chk("asr", q8, 8'hC8);
    chk("asr_so", {so_l8, so_r8}, 2'b10);
    mode = 3'b000;
    tick(); tick(); tick(); chk("hold3", q8, 8'hC8);
    mode = 3'b111;
    tick(); chk("reserved_hold", q8, 8'hC8);
    mode = 3'b001; en = 1'b0;
    tick(); chk("en0_hold", q8, 8'hC8);

    // Burst ROL x3 from A5; mode/d disturbance during RUN and start during DONE
    en = 1'b1; mode = 3'b011; d = 8'hA5;
    tick(); chk("b_load", q8, 8'hA5);
    mode = 3'b101; count = 4'd3; start = 1'b1;
    tick(); chk("b_acc_q", q8, 8'hA5);
    chk("b_acc_bd", {busy8, done8}, 2'b10);
    start = 1'b0; mode = 3'b011; d = 8'hFF;
    tick(); chk("b_s1", {busy8, done8, q8}, {2'b10, 8'h4B});
    tick(); chk("b_s2", {busy8, done8, q8}, {2'b10, 8'h96});
    tick(); chk("b_s3", {busy8, done8, q8}, {2'b01, 8'h2D});
    mode = 3'b101; start = 1'b1;
    tick(); chk("b_after_done", {busy8, done8, q8}, {2'b00, 8'h2D});
    start = 1'b0; mode = 3'b000;
    tick(); chk("b_idle", {busy8, done8, q8}, {2'b00, 8'h2D});

    // Stall: en low for two RUN edges after the first step
    mode = 3'b011; d = 8'hA5;
    tick();
    mode = 3'b101; count = 4'd3; start = 1'b1;
    tick(); chk("st_acc", busy8, 1'b1);
    start = 1'b0; mode = 3'b000;
    tick(); chk("st_s1", {busy8, q8}, {1'b1, 8'h4B});
    en = 1'b0;
    tick(); chk("st_stall1", {busy8, done8, q8}, {2'b10, 8'h4B});
    tick(); chk("st_stall2", {busy8, done8, q8}, {2'b10, 8'h4B});
    en = 1'b1;
    tick(); chk("st_s2", {busy8, done8, q8}, {2'b10, 8'h96});
    tick(); chk("st_s3", {busy8, done8, q8}, {2'b01, 8'h2D});
    tick(); chk("st_end", {busy8, done8}, 2'b00);

    // Rejected starts: zero count, then non-burst modes
    mode = 3'b011; d = 8'h3C; count = 4'd0; start = 1'b1;
    tick(); chk("rej_cnt0", {busy8, q8}, {1'b0, 8'h3C});
    mode = 3'b000; count = 4'd5;
    tick(); chk("rej_hold", {busy8, q8}, {1'b0, 8'h3C});
    mode = 3'b111;
    tick(); chk("rej_rsvd", {busy8, q8}, {1'b0, 8'h3C});
    start = 1'b0; mode = 3'b000;
    tick(); chk("rej_idle", {busy8, done8}, 2'b00);

    // Reset mid-burst, then a fresh burst
    mode = 3'b011; d = 8'hA5;
    tick();
    mode = 3'b100; count = 4'd7; start = 1'b1;
    tick(); chk("mr_acc", busy8, 1'b1);
    start = 1'b0; mode = 3'b000;
    tick(); chk("mr_s1", q8, 8'hD2);
    tick(); chk("mr_s2", q8, 8'h69);
    clr = 1'b1;
    tick(); chk("mr_clr", {busy8, done8, so_l8, so_r8, q8}, {4'b0000, 8'h00});
    clr = 1'b0;
    tick(); chk("mr_nodone", {busy8, done8, q8}, {2'b00, 8'h00});
    mode = 3'b011; d = 8'h81;
    tick();
    mode = 3'b101; count = 4'd2; start = 1'b1;
    tick(); chk("fr_acc", busy8, 1'b1);
    start = 1'b0; mode = 3'b000;
    tick(); chk("fr_s1", {busy8, done8, q8}, {2'b10, 8'h03});
    tick(); chk("fr_s2", {busy8, done8, q8}, {2'b01, 8'h06});
    tick(); chk("fr_end", {busy8, done8}, 2'b00);

    // Wrap: eight rotations restore the value; fifteen rotations of 01 give 80
    mode = 3'b011; d = 8'h5A;
    tick();
    burst(3'b101, 4'd8, busy_cyc, done_cyc);
    chk("wrap8_q", q8, 8'h5A);
    chk("wrap8_busy", busy_cyc, 8);
    chk("wrap8_done", done_cyc, 1);
    mode = 3'b011; d = 8'h01;
    tick();
    burst(3'b101, 4'd15, busy_cyc, done_cyc);
    chk("rol15_q", q8, 8'h80);
    chk("rol15_busy", busy_cyc, 15);
    chk("rol15_done", done_cyc, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
